// File: rtl/guess_ctrl.sv
// Guess-number round controller: assembles digits, compares against a latched secret, counts attempts.
// Latency: digit/clear take effect at the next edge; submit -> CHECK for one cycle -> result/check_valid after the following edge.
// Backpressure: none; strobes arriving while an event cannot be honoured are dropped.
module guess_ctrl #(
    parameter int DIGITS    = 3,
    parameter int MAX_TRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            hex,
    input  logic                  pulse,
    input  logic                  start,
    input  logic                  submit,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   secret,
    output logic [4*DIGITS-1:0]   guess,
    output logic [2:0]            digit_cnt,
    output logic [3:0]            try_cnt,
    output logic [1:0]            result,
    output logic                  check_valid,
    output logic [2:0]            state,
    output logic                  win,
    output logic                  lose
);

    localparam int GW = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_CHECK = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   secret_q, secret_d;
    logic [GW-1:0]   guess_q, guess_d;
    logic [2:0]      digit_cnt_q, digit_cnt_d;
    logic [3:0]      try_cnt_q, try_cnt_d;
    logic [1:0]      result_q, result_d;
    logic            check_valid_q, check_valid_d;

    logic            full;
    logic [3:0]      try_next;

    assign full     = (digit_cnt_q == 3'(DIGITS));
    assign try_next = try_cnt_q + 4'd1;

    // Next-state and datapath updates; every register holds unless an event says otherwise.
    always_comb begin
        state_d       = state_q;
        secret_d      = secret_q;
        guess_d       = guess_q;
        digit_cnt_d   = digit_cnt_q;
        try_cnt_d     = try_cnt_q;
        result_d      = result_q;
        check_valid_d = 1'b0;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                // A new round starts only from a resting state; the secret is captured here and only here.
                if (start) begin
                    secret_d    = secret;
                    guess_d     = '0;
                    digit_cnt_d = '0;
                    try_cnt_d   = '0;
                    result_d    = 2'b00;
                    state_d     = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clear) begin
                    guess_d     = '0;
                    digit_cnt_d = '0;
                end else if (submit) begin
                    if (full) state_d = S_CHECK;
                end else if (pulse && !full) begin
                    // Newest digit enters at the low nibble; the oldest falls off the top.
                    guess_d     = (guess_q << 4) | GW'(hex);
                    digit_cnt_d = digit_cnt_q + 3'd1;
                end
            end
            S_CHECK: begin
                check_valid_d = 1'b1;
                try_cnt_d     = try_next;
                if (guess_q < secret_q) begin
                    result_d = 2'b01;
                end else if (guess_q > secret_q) begin
                    result_d = 2'b10;
                end else begin
                    result_d = 2'b11;
                end
                if (guess_q == secret_q) begin
                    state_d = S_WIN;
                end else if (try_next == 4'(MAX_TRIES)) begin
                    state_d = S_LOSE;
                end else begin
                    state_d     = S_ENTRY;
                    guess_d     = '0;
                    digit_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            secret_q      <= '0;
            guess_q       <= '0;
            digit_cnt_q   <= '0;
            try_cnt_q     <= '0;
            result_q      <= 2'b00;
            check_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            secret_q      <= secret_d;
            guess_q       <= guess_d;
            digit_cnt_q   <= digit_cnt_d;
            try_cnt_q     <= try_cnt_d;
            result_q      <= result_d;
            check_valid_q <= check_valid_d;
        end
    end

    assign guess       = guess_q;
    assign digit_cnt   = digit_cnt_q;
    assign try_cnt     = try_cnt_q;
    assign result      = result_q;
    assign check_valid = check_valid_q;
    assign state       = state_q;
    assign win         = (state_q == S_WIN);
    assign lose        = (state_q == S_LOSE);

endmodule

// File: tb/tb_guess_ctrl.sv
// Testbench for guess_ctrl: directed round scenarios followed by randomized strobes.
// Every cycle all outputs are compared against a behavioural game model.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after the edge.
module tb_guess_ctrl;

    localparam int DIGITS    = 3;
    localparam int MAX_TRIES = 8;
    localparam int GW        = 4 * DIGITS;

    logic            clk;
    logic            rst;
    logic [3:0]      hex;
    logic            pulse, start, submit, clear;
    logic [GW-1:0]   secret;
    logic [GW-1:0]   guess;
    logic [2:0]      digit_cnt;
    logic [3:0]      try_cnt;
    logic [1:0]      result;
    logic            check_valid;
    logic [2:0]      state;
    logic            win, lose;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the game (plain integers).
    int m_state  = 0;  // 0 idle, 1 entry, 2 check, 3 win, 4 lose
    int m_secret = 0;
    int m_guess  = 0;
    int m_digits = 0;
    int m_tries  = 0;
    int m_result = 0;
    int m_cv     = 0;

    guess_ctrl #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .rst(rst), .hex(hex), .pulse(pulse), .start(start),
        .submit(submit), .clear(clear), .secret(secret), .guess(guess),
        .digit_cnt(digit_cnt), .try_cnt(try_cnt), .result(result),
        .check_valid(check_valid), .state(state), .win(win), .lose(lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        m_cv = 0;
        if (rst) begin
            m_state = 0; m_guess = 0; m_digits = 0; m_tries = 0; m_result = 0;
        end else if (m_state == 1) begin
            if (clear) begin
                m_guess = 0; m_digits = 0;
            end else if (submit) begin
                if (m_digits == DIGITS) m_state = 2;
            end else if (pulse && m_digits < DIGITS) begin
                m_guess  = (m_guess * 16 + int'(hex)) % (1 << GW);
                m_digits = m_digits + 1;
            end
        end else if (m_state == 2) begin
            m_tries = m_tries + 1;
            m_cv    = 1;
            if (m_guess < m_secret)      m_result = 1;
            else if (m_guess > m_secret) m_result = 2;
            else                         m_result = 3;
            if (m_result == 3)            m_state = 3;
            else if (m_tries == MAX_TRIES) m_state = 4;
            else begin
                m_state = 1; m_guess = 0; m_digits = 0;
            end
        end else if (start) begin
            m_secret = int'(secret);
            m_guess = 0; m_digits = 0; m_tries = 0; m_result = 0;
            m_state = 1;
        end
    endtask

    task automatic compare_all();
        chk("state",       32'(state),       m_state);
        chk("guess",       32'(guess),       m_guess);
        chk("digit_cnt",   32'(digit_cnt),   m_digits);
        chk("try_cnt",     32'(try_cnt),     m_tries);
        chk("result",      32'(result),      m_result);
        chk("check_valid", 32'(check_valid), m_cv);
        chk("win",         32'(win),         32'(m_state == 3));
        chk("lose",        32'(lose),        32'(m_state == 4));
    endtask

    // One clock: present inputs, take the edge, update the model, compare.
    task automatic step(input logic r, input logic st, input logic sb,
                        input logic cl, input logic pl, input logic [3:0] h);
        rst = r; start = st; submit = sb; clear = cl; pulse = pl; hex = h;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic digit(input logic [3:0] h);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, h);
    endtask

    task automatic do_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    // Submit then let CHECK resolve.
    task automatic do_submit();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        idle_cycle();
    endtask

    function automatic logic [GW-1:0] small_secret();
        logic [GW-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) v = (v << 4) | GW'($urandom_range(0, 2));
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; submit = 1'b0; clear = 1'b0; pulse = 1'b0;
        hex = 4'h0; secret = 12'h000;
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("reset_state", 32'(state), 32'd0);

        // Reset during entry with two digits in.
        secret = 12'h345;
        do_start();
        digit(4'h3); digit(4'h4);
        chk("mid_entry_cnt", 32'(digit_cnt), 32'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("rst_entry_guess", 32'(guess), 32'd0);
        chk("rst_entry_state", 32'(state), 32'd0);

        // Correct guess on the first attempt.
        do_start();
        digit(4'h3); digit(4'h4); digit(4'h5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("check_state", 32'(state), 32'd2);
        chk("no_cv_in_check", 32'(check_valid), 32'd0);
        idle_cycle();
        chk("win_result", 32'(result), 32'd3);
        chk("win_cv", 32'(check_valid), 32'd1);
        chk("win_tries", 32'(try_cnt), 32'd1);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_guess", 32'(guess), 32'h345);
        idle_cycle();
        chk("cv_one_cycle", 32'(check_valid), 32'd0);
        do_submit();
        digit(4'h9);
        chk("win_holds_guess", 32'(guess), 32'h345);

        // Too small then too big; secret input changes and start is asserted mid-round.
        do_start();
        secret = 12'h999;
        digit(4'h2); digit(4'h0); digit(4'h0);
        do_submit();
        chk("small_result", 32'(result), 32'd1);
        chk("small_back_entry", 32'(state), 32'd1);
        chk("small_guess_clr", 32'(guess), 32'd0);
        do_start();
        chk("start_ignored", 32'(state), 32'd1);
        digit(4'h7); digit(4'h0); digit(4'h0);
        do_submit();
        chk("big_result", 32'(result), 32'd2);
        chk("big_tries", 32'(try_cnt), 32'd2);

        // Early submit ignored, overflow digit ignored, clear beats pulse.
        digit(4'h1); digit(4'h2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("early_submit", 32'(state), 32'd1);
        digit(4'h3); digit(4'h6);
        chk("full_guess", 32'(guess), 32'h123);
        chk("full_cnt", 32'(digit_cnt), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8);
        chk("clear_guess", 32'(guess), 32'd0);
        chk("clear_cnt", 32'(digit_cnt), 32'd0);

        // Exhaust all tries.
        secret = 12'h345;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        do_start();
        for (int t = 0; t < MAX_TRIES; t++) begin
            digit(4'h0); digit(4'h0); digit(4'h0);
            do_submit();
        end
        chk("lose_tries", 32'(try_cnt), 32'(MAX_TRIES));
        chk("lose_flag", 32'(lose), 32'd1);
        digit(4'h1);
        do_submit();
        chk("lose_holds", 32'(state), 32'd4);
        secret = 12'h111;
        do_start();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_tries", 32'(try_cnt), 32'd0);
        chk("restart_result", 32'(result), 32'd0);

        // Randomized play with a narrow digit alphabet so wins occur.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) == 0) secret = small_secret();
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 1) == 0),
                 4'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
